// File: rtl/dp_ctxt_rdstream_pkg.sv
// rtl/dp_ctxt_rdstream_pkg.sv - shared defaults, state type and width helper for the ciphertext read-out stream
package dp_ctxt_rdstream_pkg;

  function automatic int data_width(input int num_poly, input int coe_width);
    return 2 * num_poly * coe_width;
  endfunction

  localparam int DEF_COE_WIDTH  = 35;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_NUM_POLY   = 3;
  localparam int DEF_NUM_SPLIT  = 4;
  localparam int DEF_URAM_DELAY = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_DATA_WIDTH = data_width(DEF_NUM_POLY, DEF_COE_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } rd_state_t;

endpackage

// File: rtl/dp_ctxt_rdstream_if.sv
// rtl/dp_ctxt_rdstream_if.sv - valid/ready word stream toward the DMA/host side
interface dp_ctxt_rdstream_if
  import dp_ctxt_rdstream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dp_sync_fifo.sv
// rtl/dp_sync_fifo.sv - synchronous FIFO with registered head, push/pop and occupancy count
module dp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  // Head is driven only from state registers; zeroed while empty so idle outputs read 0
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                               !(push && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/dp_ctxt_rdstream.sv
// rtl/dp_ctxt_rdstream.sv - sweeps one URAM split in address order and streams each word out
// with credit-based issue so the fixed read latency never overruns the output buffer.
module dp_ctxt_rdstream
  import dp_ctxt_rdstream_pkg::*;
#(
  parameter int COE_WIDTH  = DEF_COE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_POLY   = DEF_NUM_POLY,
  parameter int NUM_SPLIT  = DEF_NUM_SPLIT,
  parameter int URAM_DELAY = DEF_URAM_DELAY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int DW        = data_width(NUM_POLY, COE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_idx_split,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_idx_split,
  output logic [NUM_SPLIT-1:0]  o_uram_mem_en,
  output logic [ADDR_WIDTH-1:0] o_uram_rdaddr,
  input  logic [DW-1:0]         i_uram_dout,
  dp_ctxt_rdstream_if.master    m_axis
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t             state;
  logic [ADDR_WIDTH:0]   remaining;
  logic [URAM_DELAY-1:0] pipe_v;
  logic [URAM_DELAY-1:0] pipe_l;
  logic [CW-1:0]         inflight_cnt;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_sum;
  logic                  issue;
  logic                  issue_last;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  head_last;
  logic [DW-1:0]         head_data;

  // Every read in flight owns a FIFO slot, so a push can never find the buffer full
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_cnt};
  assign issue      = (state == ST_RUN) && (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign issue_last = (remaining == (ADDR_WIDTH+1)'(1));
  assign push       = pipe_v[URAM_DELAY-1];
  assign pop        = !fifo_empty && m_axis.tready;

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = head_data;
  assign m_axis.tlast  = head_last;

  dp_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pipe_l[URAM_DELAY-1], i_uram_dout}),
    .pop       (pop),
    .pop_data  ({head_last, head_data}),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v       <= '0;
      pipe_l       <= '0;
      inflight_cnt <= '0;
    end else begin
      pipe_v       <= {pipe_v[URAM_DELAY-2:0], issue};
      pipe_l       <= {pipe_l[URAM_DELAY-2:0], issue && issue_last};
      inflight_cnt <= inflight_cnt + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_idx_split   <= '0;
      o_uram_mem_en <= '0;
      o_uram_rdaddr <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (int'(i_idx_split) >= NUM_SPLIT) begin
              o_err <= 1'b1;
            end else if (i_num_words == '0) begin
              o_done <= 1'b1;
            end else begin
              state         <= ST_RUN;
              o_busy        <= 1'b1;
              o_idx_split   <= i_idx_split;
              o_uram_mem_en <= NUM_SPLIT'(1) << i_idx_split;
              o_uram_rdaddr <= '0;
              remaining     <= i_num_words;
            end
          end
        end
        ST_RUN: begin
          // Length is counted down rather than compared to the address, so 4096 words wrap cleanly
          if (issue) begin
            o_uram_rdaddr <= o_uram_rdaddr + ADDR_WIDTH'(1);
            remaining     <= remaining - (ADDR_WIDTH+1)'(1);
            if (issue_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state         <= ST_IDLE;
            o_busy        <= 1'b0;
            o_done        <= 1'b1;
            o_uram_mem_en <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dp_ctxt_rdstream.sv
// tb/tb_dp_ctxt_rdstream.sv - randomized scoreboard bench for dp_ctxt_rdstream against a URAM model
module tb_dp_ctxt_rdstream;
  localparam int DW         = 210;
  localparam int URAM_DELAY = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    idx_split;
  logic [12:0]   num_words;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    o_idx;
  logic [2:0]    mem_en;
  logic [11:0]   rdaddr;
  logic [DW-1:0] uram_dout;
  logic [DW-1:0] upipe [URAM_DELAY];

  dp_ctxt_rdstream_if #(.DATA_WIDTH(DW)) axis ();

  dp_ctxt_rdstream #(
    .NUM_SPLIT (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_idx_split   (idx_split),
    .i_num_words   (num_words),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_idx_split   (o_idx),
    .o_uram_mem_en (mem_en),
    .o_uram_rdaddr (rdaddr),
    .i_uram_dout   (uram_dout),
    .m_axis        (axis)
  );

  beat_t exp_q [$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    ready_mode = 1;
  bit    allow_done = 0;
  bit    allow_err  = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] uram_word(input int s, input int a);
    logic [223:0] t;
    for (int i = 0; i < 7; i++) begin
      t[i*32 +: 32] = (32'(s) << 28) ^ (32'(a) * 32'h9E3779B1) ^ (32'(i) << 20) ^ 32'(a);
    end
    return t[DW-1:0];
  endfunction

  function automatic int split_of(input logic [2:0] en);
    int sel = 0;
    for (int i = 0; i < 3; i++) if (en[i]) sel = i;
    return sel;
  endfunction

  // URAM: the word addressed in one cycle appears on dout URAM_DELAY cycles later
  always @(posedge clk) begin
    upipe[0] <= (mem_en != 3'b000) ? uram_word(split_of(mem_en), int'(rdaddr)) : '0;
    for (int i = 1; i < URAM_DELAY; i++) upipe[i] <= upipe[i-1];
  end
  assign uram_dout = upipe[URAM_DELAY-1];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      axis.tready = 1'b1;
      else if (ready_mode == 0) axis.tready = 1'b0;
      else                      axis.tready = ($urandom_range(0, 99) < 30);
    end
  end

  // Monitor: scoreboard pops, stall stability, done timing, spurious pulses
  initial begin
    bit            prev_stall = 0;
    bit            prev_last_hs = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_tlast = 0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          check("stall_tvalid", 256'(axis.tvalid), 256'(1));
          check("stall_tdata", 256'(axis.tdata), 256'(prev_data));
          check("stall_tlast", 256'(axis.tlast), 256'(prev_tlast));
        end
        if (prev_last_hs) check("done_after_last", 256'({done, busy}), 256'(2'b10));
        else if (done && !allow_done) check("spurious_done", 256'(done), 256'(0));
        if (err && !allow_err) check("spurious_err", 256'(err), 256'(0));
        if (axis.tvalid && axis.tready) begin
          if (exp_q.size() == 0) check("extra_beat", 256'(1), 256'(exp_q.size()));
          else begin
            e = exp_q.pop_front();
            check("tdata", 256'(axis.tdata), 256'(e.data));
            check("tlast", 256'(axis.tlast), 256'(e.last));
          end
        end
        prev_stall   = axis.tvalid && !axis.tready;
        prev_data    = axis.tdata;
        prev_tlast   = axis.tlast;
        prev_last_hs = axis.tvalid && axis.tready && axis.tlast;
      end else begin
        prev_stall   = 0;
        prev_last_hs = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_err"}, 256'(err), 256'(0));
    check({tag, "_idx"}, 256'(o_idx), 256'(0));
    check({tag, "_mem_en"}, 256'(mem_en), 256'(0));
    check({tag, "_rdaddr"}, 256'(rdaddr), 256'(0));
    check({tag, "_tvalid"}, 256'(axis.tvalid), 256'(0));
    check({tag, "_tlast"}, 256'(axis.tlast), 256'(0));
    check({tag, "_tdata"}, 256'(axis.tdata), 256'(0));
  endtask

  task automatic run_job(input int s, input int n, input int rmode, input bit timing, input bit poke);
    int         k;
    bit         got;
    logic [2:0] oh;
    oh = 3'b001 << s;
    ready_mode = rmode;
    @(negedge clk);
    check("idle_mem_en", 256'(mem_en), 256'(0));
    for (int a = 0; a < n; a++) exp_q.push_back('{data: uram_word(s, a), last: (a == n - 1)});
    start = 1; idx_split = 2'(s); num_words = 13'(n);
    k = 0; got = 0;
    while (!got && k < 64) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 0;
        check("first_addr", 256'(rdaddr), 256'(0));
        check("job_mem_en", 256'(mem_en), 256'(oh));
        check("job_busy", 256'(busy), 256'(1));
        check("job_idx", 256'(o_idx), 256'(s));
      end
      if (poke && k == 3) begin start = 1; idx_split = 2'd0; num_words = 13'd5; end
      if (poke && k == 4) start = 0;
      if (axis.tvalid) got = 1;
    end
    if (timing) check("first_tvalid_cycle", 256'(k), 256'(URAM_DELAY + 2));
    if (rmode == 1) begin
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        check("no_bubble", 256'(axis.tvalid), 256'(1));
      end
    end
    for (int c = 0; c < n * 20 + 200 && busy; c++) @(negedge clk);
    check("job_end_busy", 256'(busy), 256'(0));
    check("job_end_queue", 256'(exp_q.size()), 256'(0));
    check("job_end_mem_en", 256'(mem_en), 256'(0));
    check("job_end_tvalid", 256'(axis.tvalid), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; idx_split = 0; num_words = 0; axis.tready = 1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    run_job(2, 16, 1, 1, 0);

    @(negedge clk);
    allow_err = 1;
    start = 1; idx_split = 2'd3; num_words = 13'd8;
    @(negedge clk);
    start = 0;
    check("err_pulse", 256'(err), 256'(1));
    check("err_busy", 256'(busy), 256'(0));
    @(negedge clk);
    check("err_single", 256'(err), 256'(0));
    check("err_mem_en", 256'(mem_en), 256'(0));
    allow_err = 0;

    allow_done = 1;
    start = 1; idx_split = 2'd1; num_words = 13'd0;
    @(negedge clk);
    start = 0;
    check("zero_done", 256'(done), 256'(1));
    check("zero_busy", 256'(busy), 256'(0));
    check("zero_mem_en", 256'(mem_en), 256'(0));
    check("zero_tvalid", 256'(axis.tvalid), 256'(0));
    @(negedge clk);
    check("zero_done_single", 256'(done), 256'(0));
    allow_done = 0;

    run_job(0, 4096, 1, 1, 0);
    run_job(1, 32, 2, 0, 0);
    run_job(2, 24, 2, 1, 1);

    ready_mode = 0;
    @(negedge clk);
    for (int a = 0; a < 20; a++) exp_q.push_back('{data: uram_word(0, a), last: (a == 19)});
    start = 1; idx_split = 2'd0; num_words = 13'd20;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    check("stall_rdaddr", 256'(rdaddr), 256'(8));
    check("stall_tvalid_held", 256'(axis.tvalid), 256'(1));
    check("stall_busy", 256'(busy), 256'(1));
    rst_n = 0;
    @(negedge clk);
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    run_job(1, 10, 1, 1, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
